mem_request_arbiter: RTL
========================

# mem_request_arbiter

Shares the single-ported RAM between the instruction-fetch path (PC) and the data load/store path (memload/writeData) of the core. Each side raises a request and holds it until a one-cycle ready pulse. A three-state FSM grants the RAM to one side at a time, captures that side's address and write data, waits for the RAM acknowledge, returns read data in a register and pulses that side's ready. A watchdog aborts transactions the RAM never acknowledges.

## Interface
- `TIMEOUT`, default 255: cycles a granted transaction may wait for `ram_ack` before it is aborted; legal range 1..65535.
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: synchronous reset, active-high.
- `i_req` input 1: fetch request, held high until `i_ready`.
- `i_addr` input 32: fetch address.
- `i_rdata` output 32: fetched instruction, registered.
- `i_ready` output 1: one-cycle fetch-complete pulse.
- `d_ren` input 1: data load request, held until `d_ready`.
- `d_wen` input 1: data store request, held until `d_ready`.
- `d_addr` input 32: data address.
- `d_wdata` input 32: store data.
- `d_rdata` output 32: load data, registered.
- `d_ready` output 1: one-cycle data-complete pulse.
- `ram_addr` output 32: RAM address, registered.
- `ram_wdata` output 32: RAM write data, registered.
- `ram_ren` output 1: RAM read strobe.
- `ram_wen` output 1: RAM write strobe.
- `ram_rdata` input 32: RAM read data, valid when `ram_ack` is high.
- `ram_ack` input 1: RAM completion, sampled while a strobe is high.
- `err` output 1: sticky timeout flag.

## Operation
- States:
  - IDLE: no strobes.
  - FETCH: `ram_ren`=1.
  - DATA: `ram_ren`=`d_ren & ~d_wen`, `ram_wen`=`d_wen`.
- Grant in IDLE:
  - Data wins over fetch by default.
  - Exception: if the previous completed transaction was DATA and `i_req` is high, FETCH is granted. This is a 1-bit `fetch_pri` flag that prevents fetch starvation.
  - `fetch_pri` is set on DATA completion and cleared on FETCH completion.
- Capture on grant:
  - `ram_addr` takes `i_addr` or `d_addr`.
  - On a DATA grant, `ram_wdata` takes `d_wdata`.
  - Requester inputs are ignored for the rest of the transaction.
- `d_ren` and `d_wen` both high: treated as a store. No load data is returned and `d_rdata` is unchanged.
- Completion (`ram_ack`=1 in FETCH or DATA):
  - FETCH: `i_rdata`<=`ram_rdata`, pulse `i_ready`, return to IDLE.
  - DATA load: `d_rdata`<=`ram_rdata`, pulse `d_ready`, return to IDLE.
  - DATA store: pulse `d_ready` only, return to IDLE.
- `ram_ack` in IDLE is ignored.
- Watchdog:
  - 16-bit counter, cleared on every grant, incremented each cycle in FETCH/DATA without `ram_ack`.
  - When the count reaches `TIMEOUT`, return to IDLE and set `err`=1.
  - The aborted side's ready **is** pulsed, so the core never hangs; its rdata register is left unchanged.
- `err` is cleared only by `rst`.
- Requests dropped mid-transaction are not an error. The transaction completes, and the ready pulse is still issued.

## Timing
- Reset values:
  - State IDLE.
  - `ram_ren`/`ram_wen`/`i_ready`/`d_ready`/`err`/`fetch_pri` = 0.
  - `ram_addr`/`ram_wdata`/`i_rdata`/`d_rdata` = 0.
  - Counter = 0.
- Request sampled high in IDLE at edge N: state and strobes are high from N+1.
- `ram_ack` high during cycle M (M ≥ N+1): ready pulse and rdata are valid from edge M+1 for exactly one cycle; state is IDLE at M+1.
- Best-case latency (request to ready): 2 cycles.
- Back-to-back transactions:
  - The next grant is evaluated in the IDLE cycle that coincides with the ready pulse.
  - A requester holding its request through the ready cycle is granted again, so its strobe rises one cycle after ready.
  - Requesters must drop their request in the ready cycle unless they want another transaction.
- `rst` high at any edge:
  - All outputs return to reset values at that edge, including strobes.
  - An in-flight transaction is discarded with no ready pulse.
  - `ram_ack` in that cycle is ignored.
- Timeout: abort happens at the edge where the counter equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after the grant. Ready pulses on that edge.
- `ram_ack` and timeout in the same cycle: the ack wins. Normal completion, `err` is not set.

## Test plan
- Fetch only: `i_req`=1, `i_addr`=0x0000_0040, ack one cycle after `ram_ren` rises with `ram_rdata`=0x0051_0093 -> `ram_addr`=0x40, `i_ready` pulses 3 cycles after the request, `i_rdata`=0x0051_0093.
- Simultaneous requests: `i_req`=1 and `d_ren`=1 (`d_addr`=0x100) in the same cycle, all held, RAM acks immediately -> DATA granted first. FETCH is then granted on the cycle after `d_ready` despite `d_ren` being re-asserted, verifying `fetch_pri`.
- Store: `d_wen`=1, `d_addr`=0x200, `d_wdata`=0xDEAD_BEEF, 3-cycle RAM latency -> `ram_wen`=1 and `ram_ren`=0 for 3 cycles with captured address/data, `d_ready` pulses, `d_rdata` unchanged. Repeat with `d_ren`=`d_wen`=1 -> identical behaviour.
- Timeout: `TIMEOUT`=4, `i_req`=1, no ack -> strobe high 5 cycles, `i_ready` pulses, `i_rdata` unchanged, `err`=1 and stays 1 through later successful transactions until `rst`.
- Reset mid-operation: `rst`=1 for one cycle during a DATA wait -> strobes 0 next cycle, no `d_ready`, state IDLE. A held `d_ren` is re-granted on the first cycle after `rst` falls.
- Ack/timeout collision: `TIMEOUT`=2, ack arrives exactly on the timeout cycle -> normal completion with data captured and `err`=0.

Source files
------------

// File: rtl/mem_request_arbiter_if.sv
// mem_request_arbiter_if: requester and RAM signals of the fetch/data memory arbiter
interface mem_request_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        err;

    modport slave (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_ack,
        output i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen, err
    );

    modport master (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_ack,
        input  i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen, err
    );
endinterface

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: shares one RAM port between fetch and data paths, with a timeout watchdog
module mem_request_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst,
    mem_request_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        fetch_pri_q, err_q, i_ready_q, d_ready_q, ram_ren_q, ram_wen_q;
    logic [31:0] i_rdata_q, d_rdata_q, ram_addr_q, ram_wdata_q;
    logic        d_req, busy, grant_f, grant_d, done, abort;

    assign d_req   = bus.d_ren | bus.d_wen;
    assign busy    = state_q != IDLE;
    assign grant_f = !busy && bus.i_req && (fetch_pri_q || !d_req);
    assign grant_d = !busy && d_req && !grant_f;
    assign done    = busy && bus.ram_ack;
    // ack beats timeout when both land in the same cycle
    assign abort   = busy && !bus.ram_ack && cnt_q == 16'(TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fetch_pri_q <= 1'b0;
            err_q       <= 1'b0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            if (grant_f) begin
                state_q    <= FETCH;
                ram_addr_q <= bus.i_addr;
                ram_ren_q  <= 1'b1;
                ram_wen_q  <= 1'b0;
                cnt_q      <= '0;
            end else if (grant_d) begin
                state_q     <= DATA;
                ram_addr_q  <= bus.d_addr;
                ram_wdata_q <= bus.d_wdata;
                ram_ren_q   <= bus.d_ren & ~bus.d_wen;
                ram_wen_q   <= bus.d_wen;
                cnt_q       <= '0;
            end else if (done || abort) begin
                state_q     <= IDLE;
                ram_ren_q   <= 1'b0;
                ram_wen_q   <= 1'b0;
                fetch_pri_q <= state_q == DATA;
                i_ready_q   <= state_q == FETCH;
                d_ready_q   <= state_q == DATA;
                if (done && state_q == FETCH)
                    i_rdata_q <= bus.ram_rdata;
                if (done && state_q == DATA && ram_ren_q)
                    d_rdata_q <= bus.ram_rdata;
                if (abort)
                    err_q <= 1'b1;
            end else if (busy) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_ren   = ram_ren_q;
    assign bus.ram_wen   = ram_wen_q;
    assign bus.err       = err_q;
endmodule
